// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register. It captures the decoded operands and control of
// the ID instruction on every rising edge and presents them to EX. It also:
//   - detects load-use hazards against the load currently in EX and requests
//     a stall, inserting one bubble into EX;
//   - bypasses same-cycle WB writes into the captured operands (regfile
//     write-through), never for x0;
//   - squashes the ID instruction on flush, and freezes on a memory hold.
//
// Edge priority: flush > hold > load-use hazard > normal load.
//
// Optional feature (macro IDEX_PERF_CNT_EN):
//   defined   -> o_stall_cnt / o_flush_cnt count hazard and flush bubbles
//                (wrapping 32-bit counters, cleared on reset).
//   undefined -> both ports are tied to 0 and no counter flops are built.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   i_id_*                       decoded ID-stage instruction fields
//   i_wb_rd/reg_write/data       same-cycle regfile write from WB
//   i_flush                      squash the ID instruction (EX redirect)
//   i_hold                       freeze this register (memory stall)
//   o_stall                      load-use stall request (combinational)
//   o_ex_*                       registered copies presented to EX
//   o_stall_cnt, o_flush_cnt     bubble counters (see macro above)
// ----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_id_valid,
    input  logic [XLEN-1:0]     i_id_pc,
    input  logic [4:0]          i_id_rs1,
    input  logic [4:0]          i_id_rs2,
    input  logic                i_id_uses_rs1,
    input  logic                i_id_uses_rs2,
    input  logic [4:0]          i_id_rd,
    input  logic [XLEN-1:0]     i_id_rs1_data,
    input  logic [XLEN-1:0]     i_id_rs2_data,
    input  logic [XLEN-1:0]     i_id_imm,
    input  logic [ALU_OP_W-1:0] i_id_alu_op,
    input  logic                i_id_reg_write,
    input  logic                i_id_mem_read,
    input  logic                i_id_mem_write,
    input  logic [4:0]          i_wb_rd,
    input  logic                i_wb_reg_write,
    input  logic [XLEN-1:0]     i_wb_data,
    input  logic                i_flush,
    input  logic                i_hold,
    output logic                o_stall,
    output logic                o_ex_valid,
    output logic [XLEN-1:0]     o_ex_pc,
    output logic [4:0]          o_ex_rs1,
    output logic [4:0]          o_ex_rs2,
    output logic [4:0]          o_ex_rd,
    output logic [XLEN-1:0]     o_ex_rs1_data,
    output logic [XLEN-1:0]     o_ex_rs2_data,
    output logic [XLEN-1:0]     o_ex_imm,
    output logic [ALU_OP_W-1:0] o_ex_alu_op,
    output logic                o_ex_reg_write,
    output logic                o_ex_mem_read,
    output logic                o_ex_mem_write,
    output logic [31:0]         o_stall_cnt,
    output logic [31:0]         o_flush_cnt
);

    logic            hazard;
    logic            take_bubble_hazard;
    logic [XLEN-1:0] rs1_data_fwd;
    logic [XLEN-1:0] rs2_data_fwd;

    // A load in EX whose result an ID source actually needs cannot be
    // forwarded in time; x0 loads never create a dependency.
    assign hazard = o_ex_valid & o_ex_mem_read & (o_ex_rd != 5'd0) & i_id_valid &
                    ((i_id_uses_rs1 & (i_id_rs1 == o_ex_rd)) |
                     (i_id_uses_rs2 & (i_id_rs2 == o_ex_rd)));

    // Flush and hold both override the hazard branch, so no stall is
    // requested then: a flushed op is dead, and a held pipe is frozen anyway.
    assign take_bubble_hazard = hazard & ~i_flush & ~i_hold;
    assign o_stall            = take_bubble_hazard;

    // The regfile read in ID does not yet see the value WB writes this cycle.
    assign rs1_data_fwd = (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_id_rs1))
                          ? i_wb_data : i_id_rs1_data;
    assign rs2_data_fwd = (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_id_rs2))
                          ? i_wb_data : i_id_rs2_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ex_valid     <= 1'b0;
            o_ex_pc        <= '0;
            o_ex_rs1       <= '0;
            o_ex_rs2       <= '0;
            o_ex_rd        <= '0;
            o_ex_rs1_data  <= '0;
            o_ex_rs2_data  <= '0;
            o_ex_imm       <= '0;
            o_ex_alu_op    <= '0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
        end else if (i_hold && !i_flush) begin
            // Freeze: every output keeps its value.
        end else if (i_flush || hazard || !i_id_valid) begin
            // Bubble: a fully zeroed slot, so EX forwarding sees nothing.
            o_ex_valid     <= 1'b0;
            o_ex_pc        <= '0;
            o_ex_rs1       <= '0;
            o_ex_rs2       <= '0;
            o_ex_rd        <= '0;
            o_ex_rs1_data  <= '0;
            o_ex_rs2_data  <= '0;
            o_ex_imm       <= '0;
            o_ex_alu_op    <= '0;
            o_ex_reg_write <= 1'b0;
            o_ex_mem_read  <= 1'b0;
            o_ex_mem_write <= 1'b0;
        end else begin
            o_ex_valid     <= 1'b1;
            o_ex_pc        <= i_id_pc;
            o_ex_rs1       <= i_id_rs1;
            o_ex_rs2       <= i_id_rs2;
            o_ex_rd        <= i_id_rd;
            o_ex_rs1_data  <= rs1_data_fwd;
            o_ex_rs2_data  <= rs2_data_fwd;
            o_ex_imm       <= i_id_imm;
            o_ex_alu_op    <= i_id_alu_op;
            o_ex_reg_write <= i_id_reg_write;
            o_ex_mem_read  <= i_id_mem_read;
            o_ex_mem_write <= i_id_mem_write;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (i_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (take_bubble_hazard) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = 32'd0;
    assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;

`ifdef IDEX_PERF_CNT_EN
    localparam logic [31:0] PERF_ON = 32'd1;
`else
    localparam logic [31:0] PERF_ON = 32'd0;
`endif

    logic                i_clk;
    logic                i_rst;
    logic                i_id_valid;
    logic [XLEN-1:0]     i_id_pc;
    logic [4:0]          i_id_rs1;
    logic [4:0]          i_id_rs2;
    logic                i_id_uses_rs1;
    logic                i_id_uses_rs2;
    logic [4:0]          i_id_rd;
    logic [XLEN-1:0]     i_id_rs1_data;
    logic [XLEN-1:0]     i_id_rs2_data;
    logic [XLEN-1:0]     i_id_imm;
    logic [ALU_OP_W-1:0] i_id_alu_op;
    logic                i_id_reg_write;
    logic                i_id_mem_read;
    logic                i_id_mem_write;
    logic [4:0]          i_wb_rd;
    logic                i_wb_reg_write;
    logic [XLEN-1:0]     i_wb_data;
    logic                i_flush;
    logic                i_hold;
    logic                o_stall;
    logic                o_ex_valid;
    logic [XLEN-1:0]     o_ex_pc;
    logic [4:0]          o_ex_rs1;
    logic [4:0]          o_ex_rs2;
    logic [4:0]          o_ex_rd;
    logic [XLEN-1:0]     o_ex_rs1_data;
    logic [XLEN-1:0]     o_ex_rs2_data;
    logic [XLEN-1:0]     o_ex_imm;
    logic [ALU_OP_W-1:0] o_ex_alu_op;
    logic                o_ex_reg_write;
    logic                o_ex_mem_read;
    logic                o_ex_mem_write;
    logic [31:0]         o_stall_cnt;
    logic [31:0]         o_flush_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage_reg #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
        .i_id_rd(i_id_rd), .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
        .i_id_imm(i_id_imm), .i_id_alu_op(i_id_alu_op),
        .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read),
        .i_id_mem_write(i_id_mem_write),
        .i_wb_rd(i_wb_rd), .i_wb_reg_write(i_wb_reg_write), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .i_hold(i_hold),
        .o_stall(o_stall),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc),
        .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd),
        .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
        .o_ex_imm(o_ex_imm), .o_ex_alu_op(o_ex_alu_op),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
        .o_ex_mem_write(o_ex_mem_write),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [3:0] op,
                          input logic rw, input logic mr, input logic mw);
        i_id_valid = v;      i_id_pc = pc;
        i_id_rs1 = rs1;      i_id_uses_rs1 = u1;
        i_id_rs2 = rs2;      i_id_uses_rs2 = u2;
        i_id_rd = rd;
        i_id_rs1_data = d1;  i_id_rs2_data = d2;
        i_id_imm = imm;      i_id_alu_op = op;
        i_id_reg_write = rw; i_id_mem_read = mr; i_id_mem_write = mw;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        i_wb_rd = 0; i_wb_reg_write = 0; i_wb_data = 0;
        i_flush = 0; i_hold = 0;
        #12;
        checks++;
        if (o_ex_valid !== 1'b0 || o_ex_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_init: valid=%b pc=%h expected 0/0", o_ex_valid, o_ex_pc);
        end
        i_rst = 1'b0;
        // add x3,x1,x2 at pc 0x40
        set_id(1, 32'h40, 5'd1, 1, 5'd2, 1, 5'd3, 32'h11, 32'h22, 32'h0, 4'h1, 1, 0, 0);
        step();
        checks++;
        if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h40 || o_ex_rs1_data !== 32'h11) begin
            errors++;
            $display("FAIL reset_load: valid=%b pc=%h rs1d=%h expected 1/40/11",
                     o_ex_valid, o_ex_pc, o_ex_rs1_data);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (o_ex_valid !== 1'b0 || o_ex_pc !== 32'd0 || o_ex_rs1_data !== 32'd0 ||
            o_ex_rd !== 5'd0 || o_ex_reg_write !== 1'b0 || o_ex_alu_op !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: valid=%b pc=%h rs1d=%h rd=%0d rw=%b op=%h expected all 0",
                     o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rd, o_ex_reg_write, o_ex_alu_op);
        end
        checks++;
        if (o_stall !== 1'b0 || o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: stall=%b scnt=%0d fcnt=%0d expected 0/0/0",
                     o_stall, o_stall_cnt, o_flush_cnt);
        end
        #1 i_rst = 1'b0;
    endtask

    task automatic test_load_use();
        // lw x5, 0(x2)
        set_id(1, 32'h100, 5'd2, 1, 5'd0, 0, 5'd5, 32'h0, 32'h0, 32'h0, 4'h0, 1, 1, 0);
        step();
        // add x6, x5, x1
        set_id(1, 32'h104, 5'd5, 1, 5'd1, 1, 5'd6, 32'h0, 32'h7, 32'h0, 4'h1, 1, 0, 0);
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall_on: stall=%b expected 1", o_stall);
        end
        step();
        checks++;
        if (o_ex_valid !== 1'b0 || o_ex_mem_read !== 1'b0 || o_ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL lu_bubble: valid=%b mr=%b rd=%0d expected 0/0/0",
                     o_ex_valid, o_ex_mem_read, o_ex_rd);
        end
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall_off: stall=%b expected 0", o_stall);
        end
        step();
        checks++;
        if (o_ex_valid !== 1'b1 || o_ex_rs1 !== 5'd5 || o_ex_rd !== 5'd6 || o_ex_pc !== 32'h104) begin
            errors++;
            $display("FAIL lu_add: valid=%b rs1=%0d rd=%0d pc=%h expected 1/5/6/104",
                     o_ex_valid, o_ex_rs1, o_ex_rd, o_ex_pc);
        end
        checks++;
        if (o_stall_cnt !== PERF_ON * 32'd1) begin
            errors++;
            $display("FAIL lu_stall_cnt: got %0d expected %0d", o_stall_cnt, PERF_ON);
        end
    endtask

    task automatic test_no_hazard_cases();
        // lw x0 in EX, ID reads x0
        set_id(1, 32'h200, 5'd2, 1, 5'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1, 1, 0);
        step();
        set_id(1, 32'h204, 5'd0, 1, 5'd0, 1, 5'd8, 32'h0, 32'h0, 32'h0, 4'h1, 1, 0, 0);
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: stall=%b expected 0", o_stall);
        end
        step();
        checks++;
        if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h204) begin
            errors++;
            $display("FAIL x0_nobubble: valid=%b pc=%h expected 1/204", o_ex_valid, o_ex_pc);
        end
        // lw x9 in EX, ID names x9 as rs2 but does not use it
        set_id(1, 32'h208, 5'd2, 1, 5'd0, 0, 5'd9, 32'h0, 32'h0, 32'h0, 4'h0, 1, 1, 0);
        step();
        set_id(1, 32'h20C, 5'd1, 1, 5'd9, 0, 5'd10, 32'h0, 32'h0, 32'h4, 4'h1, 1, 0, 0);
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL unused_rs2_stall: stall=%b expected 0", o_stall);
        end
        // same ID but now rs2 is used -> hazard via rs2
        i_id_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b1) begin
            errors++;
            $display("FAIL rs2_stall: stall=%b expected 1", o_stall);
        end
        i_id_uses_rs2 = 1'b0;
        step();
        checks++;
        if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h20C || o_ex_imm !== 32'h4) begin
            errors++;
            $display("FAIL unused_rs2_load: valid=%b pc=%h imm=%h expected 1/20c/4",
                     o_ex_valid, o_ex_pc, o_ex_imm);
        end
    endtask

    task automatic test_write_through();
        set_id(1, 32'h300, 5'd3, 1, 5'd7, 1, 5'd4, 32'h11, 32'h0, 32'h0, 4'h2, 1, 0, 0);
        i_wb_rd = 5'd7; i_wb_reg_write = 1'b1; i_wb_data = 32'hDEADBEEF;
        step();
        checks++;
        if (o_ex_rs2_data !== 32'hDEADBEEF || o_ex_rs1_data !== 32'h11) begin
            errors++;
            $display("FAIL wt_rs2: rs2d=%h rs1d=%h expected deadbeef/11", o_ex_rs2_data, o_ex_rs1_data);
        end
        // x0 never bypassed
        set_id(1, 32'h304, 5'd0, 1, 5'd2, 1, 5'd4, 32'h22, 32'h33, 32'h0, 4'h2, 1, 0, 0);
        i_wb_rd = 5'd0; i_wb_data = 32'h99;
        step();
        checks++;
        if (o_ex_rs1_data !== 32'h22 || o_ex_rs2_data !== 32'h33) begin
            errors++;
            $display("FAIL wt_x0: rs1d=%h rs2d=%h expected 22/33", o_ex_rs1_data, o_ex_rs2_data);
        end
        // WB enable low: no bypass even on matching index
        set_id(1, 32'h308, 5'd12, 1, 5'd0, 0, 5'd4, 32'h44, 32'h0, 32'h0, 4'h2, 1, 0, 0);
        i_wb_rd = 5'd12; i_wb_reg_write = 1'b0; i_wb_data = 32'h55;
        step();
        checks++;
        if (o_ex_rs1_data !== 32'h44) begin
            errors++;
            $display("FAIL wt_disabled: rs1d=%h expected 44", o_ex_rs1_data);
        end
        i_wb_rd = 0; i_wb_data = 0;
    endtask

    task automatic test_flush_hold();
        set_id(1, 32'h400, 5'd2, 1, 5'd0, 0, 5'd5, 32'h0, 32'h0, 32'h0, 4'h0, 1, 1, 0);
        step();
        set_id(1, 32'h404, 5'd5, 1, 5'd0, 0, 5'd6, 32'h0, 32'h0, 32'h0, 4'h1, 1, 0, 0);
        i_flush = 1'b1; i_hold = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL fh_stall: stall=%b expected 0", o_stall);
        end
        step();
        checks++;
        if (o_ex_valid !== 1'b0 || o_ex_mem_read !== 1'b0 || o_ex_reg_write !== 1'b0 || o_ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL fh_bubble: valid=%b mr=%b rw=%b rd=%0d expected 0/0/0/0",
                     o_ex_valid, o_ex_mem_read, o_ex_reg_write, o_ex_rd);
        end
        checks++;
        if (o_flush_cnt !== PERF_ON * 32'd1 || o_stall_cnt !== PERF_ON * 32'd1) begin
            errors++;
            $display("FAIL fh_cnt: fcnt=%0d scnt=%0d expected %0d/%0d",
                     o_flush_cnt, o_stall_cnt, PERF_ON, PERF_ON);
        end
        i_flush = 1'b0; i_hold = 1'b0;
    endtask

    task automatic test_hold();
        set_id(1, 32'h500, 5'd1, 1, 5'd2, 1, 5'd3, 32'hA1, 32'hA2, 32'hA3, 4'h5, 1, 0, 1);
        step();
        i_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_id(1, 32'h504 + 32'(4 * k), 5'd8, 1, 5'd9, 1, 5'd10, 32'hB0, 32'hB1, 32'hB2, 4'h7, 0, 0, 0);
            step();
            checks++;
            if (o_ex_pc !== 32'h500 || o_ex_rs1_data !== 32'hA1 || o_ex_imm !== 32'hA3 ||
                o_ex_alu_op !== 4'h5 || o_ex_mem_write !== 1'b1 || o_ex_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: pc=%h rs1d=%h imm=%h op=%h mw=%b valid=%b expected 500/a1/a3/5/1/1",
                         k, o_ex_pc, o_ex_rs1_data, o_ex_imm, o_ex_alu_op, o_ex_mem_write, o_ex_valid);
            end
        end
        i_hold = 1'b0;
        set_id(1, 32'h510, 5'd8, 1, 5'd9, 1, 5'd10, 32'hC0, 32'hC1, 32'hC2, 4'h7, 1, 0, 0);
        step();
        checks++;
        if (o_ex_pc !== 32'h510 || o_ex_rd !== 5'd10 || o_ex_rs2_data !== 32'hC1 ||
            o_ex_mem_write !== 1'b0 || o_ex_alu_op !== 4'h7) begin
            errors++;
            $display("FAIL hold_release: pc=%h rd=%0d rs2d=%h mw=%b op=%h expected 510/10/c1/0/7",
                     o_ex_pc, o_ex_rd, o_ex_rs2_data, o_ex_mem_write, o_ex_alu_op);
        end
    endtask

    task automatic test_flush_and_invalid();
        set_id(1, 32'h600, 5'd1, 1, 5'd2, 1, 5'd3, 32'h1, 32'h2, 32'h3, 4'h1, 1, 0, 0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        checks++;
        if (o_ex_valid !== 1'b0 || o_flush_cnt !== PERF_ON * 32'd2) begin
            errors++;
            $display("FAIL flush_only: valid=%b fcnt=%0d expected 0/%0d",
                     o_ex_valid, o_flush_cnt, PERF_ON * 32'd2);
        end
        set_id(0, 32'h604, 5'd1, 1, 5'd2, 1, 5'd3, 32'h1, 32'h2, 32'h3, 4'h1, 1, 1, 1);
        step();
        checks++;
        if (o_ex_valid !== 1'b0 || o_ex_reg_write !== 1'b0 || o_ex_mem_read !== 1'b0 ||
            o_ex_mem_write !== 1'b0 || o_ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL invalid_bubble: valid=%b rw=%b mr=%b mw=%b rd=%0d expected all 0",
                     o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_rd);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard_cases();
        test_write_through();
        test_flush_hold();
        test_hold();
        test_flush_and_invalid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
